// File: rtl/bus8088_pkg.sv
// rtl/bus8088_pkg.sv - shared types and defaults for the 8088 bus-cycle controller
package bus8088_pkg;

  localparam int ADDR_WIDTH_DEF = 20;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    XFER,
    DONE
  } bus_state_t;

  typedef enum logic {
    MEM = 1'b0,
    IO  = 1'b1
  } cycle_t;

endpackage

// File: rtl/bus8088_addr_decode.sv
// rtl/bus8088_addr_decode.sv - combinational memory/IO region compare on the latched address
module bus8088_addr_decode
  import bus8088_pkg::*;
#(
  parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned MEM_BASE   = 'h00000,
  parameter int unsigned MEM_SIZE   = 'h80000,
  parameter int unsigned IO_BASE    = 'h0000,
  parameter int unsigned IO_SIZE    = 'h0100
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  is_io,
  output logic                  mem_hit,
  output logic                  io_hit
);

  // Region ends are clipped to the decodable space so a large size never wraps.
  localparam longint unsigned MEM_SPAN = 64'd1 << ADDR_WIDTH;
  localparam longint unsigned IO_SPAN  = 64'h10000;
  localparam longint unsigned MEM_RAW  = longint'(MEM_BASE) + longint'(MEM_SIZE);
  localparam longint unsigned IO_RAW   = longint'(IO_BASE) + longint'(IO_SIZE);
  localparam longint unsigned MEM_END  = (MEM_RAW > MEM_SPAN) ? MEM_SPAN : MEM_RAW;
  localparam longint unsigned IO_END   = (IO_RAW > IO_SPAN) ? IO_SPAN : IO_RAW;

  localparam logic [ADDR_WIDTH:0] MEM_LO = (ADDR_WIDTH+1)'(MEM_BASE);
  localparam logic [ADDR_WIDTH:0] MEM_HI = (ADDR_WIDTH+1)'(MEM_END);
  localparam logic [ADDR_WIDTH:0] IO_LO  = (ADDR_WIDTH+1)'(IO_BASE);
  localparam logic [ADDR_WIDTH:0] IO_HI  = (ADDR_WIDTH+1)'(IO_END);

  logic [ADDR_WIDTH:0] mem_x;
  logic [ADDR_WIDTH:0] io_x;

  assign mem_x = {1'b0, addr};
  assign io_x  = (ADDR_WIDTH+1)'(addr[15:0]);

  assign mem_hit = !is_io && (mem_x >= MEM_LO) && (mem_x < MEM_HI);
  assign io_hit  =  is_io && (io_x >= IO_LO) && (io_x < IO_HI);

endmodule

// File: rtl/bus8088_cycle_ctrl.sv
// rtl/bus8088_cycle_ctrl.sv - 8088 minimum-mode bus-cycle controller with wait-state insertion
module bus8088_cycle_ctrl
  import bus8088_pkg::*;
#(
  parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned MEM_BASE   = 'h00000,
  parameter int unsigned MEM_SIZE   = 'h80000,
  parameter int unsigned IO_BASE    = 'h0000,
  parameter int unsigned IO_SIZE    = 'h0100,
  parameter int unsigned MEM_WAIT   = 1,
  parameter int unsigned IO_WAIT    = 2,
  parameter int          WAIT_W     = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ALE,
  input  logic                  IO_M,
  input  logic [ADDR_WIDTH-9:0] A_HI,
  input  logic [7:0]            AD_LO,
  input  logic                  RD_N,
  input  logic                  WR_N,
  output logic                  READY,
  output logic [ADDR_WIDTH-1:0] LAT_ADDR,
  output logic                  MEM_CS,
  output logic                  IO_CS,
  output logic                  OE_N,
  output logic                  WE_N,
  output logic                  BUS_ERR
);

  localparam logic [WAIT_W-1:0] MEM_WAIT_CNT = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] IO_WAIT_CNT  = WAIT_W'(IO_WAIT);

  bus_state_t            state_q, state_d;
  cycle_t                cyc_q, cyc_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d, wait_sel;
  logic                  ready_d, mem_cs_d, io_cs_d, oe_n_d, we_n_d, bus_err_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  mem_hit, io_hit;
  logic                  one_act, both_act, both_idle;

  assign one_act   = RD_N ^ WR_N;
  assign both_act  = !RD_N && !WR_N;
  assign both_idle = RD_N && WR_N;

  bus8088_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_BASE  (MEM_BASE),
    .MEM_SIZE  (MEM_SIZE),
    .IO_BASE   (IO_BASE),
    .IO_SIZE   (IO_SIZE)
  ) u_decode (
    .addr   (LAT_ADDR),
    .is_io  (cyc_q == IO),
    .mem_hit(mem_hit),
    .io_hit (io_hit)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    cnt_d     = cnt_q;
    addr_d    = LAT_ADDR;
    ready_d   = READY;
    mem_cs_d  = MEM_CS;
    io_cs_d   = IO_CS;
    oe_n_d    = OE_N;
    we_n_d    = WE_N;
    bus_err_d = 1'b0;
    wait_sel  = mem_hit ? MEM_WAIT_CNT : IO_WAIT_CNT;
    // ALE wins over everything: a new address phase silently aborts any cycle in flight.
    if (ALE) begin
      addr_d   = {A_HI, AD_LO};
      cyc_d    = cycle_t'(IO_M);
      state_d  = ADDR;
      ready_d  = 1'b1;
      mem_cs_d = 1'b0;
      io_cs_d  = 1'b0;
      oe_n_d   = 1'b1;
      we_n_d   = 1'b1;
    end else if (both_act && (state_q inside {ADDR, WAIT, XFER})) begin
      state_d   = DONE;
      ready_d   = 1'b1;
      mem_cs_d  = 1'b0;
      io_cs_d   = 1'b0;
      oe_n_d    = 1'b1;
      we_n_d    = 1'b1;
      bus_err_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (one_act) begin
            if (mem_hit || io_hit) begin
              mem_cs_d = mem_hit;
              io_cs_d  = io_hit;
              oe_n_d   = RD_N;
              we_n_d   = WR_N;
              cnt_d    = wait_sel;
              if (wait_sel == '0) begin
                state_d = XFER;
                ready_d = 1'b1;
              end else begin
                state_d = WAIT;
                ready_d = 1'b0;
              end
            end else begin
              state_d   = DONE;
              ready_d   = 1'b1;
              bus_err_d = 1'b1;
            end
          end
        end
        WAIT: begin
          cnt_d = cnt_q - WAIT_W'(1);
          if (cnt_d == '0) begin
            state_d = XFER;
            ready_d = 1'b1;
          end
        end
        XFER: begin
          if (both_idle) begin
            state_d  = IDLE;
            mem_cs_d = 1'b0;
            io_cs_d  = 1'b0;
            oe_n_d   = 1'b1;
            we_n_d   = 1'b1;
          end
        end
        DONE: begin
          if (both_idle) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      cyc_q    <= MEM;
      cnt_q    <= '0;
      LAT_ADDR <= '0;
      READY    <= 1'b1;
      MEM_CS   <= 1'b0;
      IO_CS    <= 1'b0;
      OE_N     <= 1'b1;
      WE_N     <= 1'b1;
      BUS_ERR  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      cnt_q    <= cnt_d;
      LAT_ADDR <= addr_d;
      READY    <= ready_d;
      MEM_CS   <= mem_cs_d;
      IO_CS    <= io_cs_d;
      OE_N     <= oe_n_d;
      WE_N     <= we_n_d;
      BUS_ERR  <= bus_err_d;
    end
  end

endmodule
